// File: rtl/minisrc_pkg.sv
// rtl/minisrc_pkg.sv - shared state encoding and width/timeout defaults for the minisrc datapath
package minisrc_pkg;

  localparam int DEF_ADDR_WIDTH     = 9;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_TIMEOUT_CYCLES = 15;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_WAIT  = 2'd1,
    ST_WR_WAIT  = 2'd2,
    ST_COMPLETE = 2'd3
  } mem_state_t;

endpackage

// File: rtl/mem_handshake_fsm.sv
// rtl/mem_handshake_fsm.sv - request/ack sequencing, timeout counter and status flags
module mem_handshake_fsm
  import minisrc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_mdr_in,
  input  logic i_read,
  input  logic i_write,
  input  logic i_mem_ack,
  output logic o_start_rd,
  output logic o_start_wr,
  output logic o_rd_done,
  output logic o_mem_req,
  output logic o_mem_we,
  output logic o_busy,
  output logic o_done,
  output logic o_error
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  mem_state_t r_state, w_state_nxt;
  logic [7:0] r_count, w_count_nxt;
  logic       r_mem_we, w_mem_we_nxt;
  logic       r_error, w_error_nxt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_count  <= 8'd0;
      r_mem_we <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_mem_we <= w_mem_we_nxt;
      r_error  <= w_error_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_mem_we_nxt = r_mem_we;
    w_error_nxt  = r_error;
    o_start_rd   = 1'b0;
    o_start_wr   = 1'b0;
    o_rd_done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Read wins a Read/Write collision; the collision itself is a fault.
        if (i_read && (i_mdr_in || i_write)) begin
          o_start_rd   = 1'b1;
          w_state_nxt  = ST_RD_WAIT;
          w_count_nxt  = 8'd0;
          w_mem_we_nxt = 1'b0;
          if (i_write) w_error_nxt = 1'b1;
        end else if (i_write) begin
          o_start_wr   = 1'b1;
          w_state_nxt  = ST_WR_WAIT;
          w_count_nxt  = 8'd0;
          w_mem_we_nxt = 1'b1;
        end
      end
      ST_RD_WAIT, ST_WR_WAIT: begin
        if (i_mem_ack) begin
          o_rd_done   = (r_state == ST_RD_WAIT);
          w_state_nxt = ST_COMPLETE;
        end else if (r_count == TIMEOUT_LAST) begin
          w_state_nxt = ST_COMPLETE;
          w_error_nxt = 1'b1;
        end else begin
          w_count_nxt = r_count + 8'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (r_state != ST_IDLE && (i_read || i_write || i_mdr_in)) w_error_nxt = 1'b1;
  end

  assign o_mem_req = (r_state == ST_RD_WAIT) || (r_state == ST_WR_WAIT);
  assign o_mem_we  = r_mem_we;
  assign o_busy    = (r_state != ST_IDLE);
  assign o_done    = (r_state == ST_COMPLETE);
  assign o_error   = r_error;

endmodule

// File: rtl/memory_interface.sv
// rtl/memory_interface.sv - MAR/MDR ownership and latched request path to a variable-latency memory
module memory_interface
  import minisrc_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_bus_mux_out,
  input  logic                  i_mar_in,
  input  logic                  i_mdr_in,
  input  logic                  i_read,
  input  logic                  i_write,
  output logic [DATA_WIDTH-1:0] o_mdr_data,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wr_data,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  input  logic [DATA_WIDTH-1:0] i_mem_rd_data,
  input  logic                  i_mem_ack,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
);

  logic [ADDR_WIDTH-1:0] r_mar, r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mdr, r_mem_wr_data;
  logic                  w_start_rd, w_start_wr, w_rd_done, w_busy;

  mem_handshake_fsm #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_fsm (
    .i_clk      (i_clock),
    .i_reset    (i_reset),
    .i_mdr_in   (i_mdr_in),
    .i_read     (i_read),
    .i_write    (i_write),
    .i_mem_ack  (i_mem_ack),
    .o_start_rd (w_start_rd),
    .o_start_wr (w_start_wr),
    .o_rd_done  (w_rd_done),
    .o_mem_req  (o_mem_req),
    .o_mem_we   (o_mem_we),
    .o_busy     (w_busy),
    .o_done     (o_done),
    .o_error    (o_error)
  );

  // Request address/data are snapshots, so MAR/MDR may change while a request is in flight.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_mar         <= '0;
      r_mdr         <= '0;
      r_mem_addr    <= '0;
      r_mem_wr_data <= '0;
    end else begin
      if (i_mar_in) r_mar <= i_bus_mux_out[ADDR_WIDTH-1:0];
      if (w_start_rd || w_start_wr) r_mem_addr <= r_mar;
      if (w_start_wr) r_mem_wr_data <= r_mdr;
      if (w_rd_done) r_mdr <= i_mem_rd_data;
      else if (!w_busy && i_mdr_in && !i_read && !i_write) r_mdr <= i_bus_mux_out;
    end
  end

  assign o_mdr_data    = r_mdr;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_wr_data = r_mem_wr_data;
  assign o_busy        = w_busy;

endmodule

// File: tb/tb_memory_interface.sv
// tb/tb_memory_interface.sv - directed plus randomized checks against a transaction-level memory model
module tb_memory_interface;

  localparam int AW  = 9;
  localparam int DW  = 32;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] bus;
  logic          mar_in, mdr_in, read, write, ack;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] mdr_data, mem_wr_data;
  logic [AW-1:0] mem_addr;
  logic          mem_req, mem_we, busy, done, err;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] tb_mem [0:511];
  logic [AW-1:0] m_mar;
  logic [DW-1:0] m_mdr;
  logic          m_err;

  always #5 clk = ~clk;

  memory_interface #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clock       (clk),
    .i_reset       (reset),
    .i_bus_mux_out (bus),
    .i_mar_in      (mar_in),
    .i_mdr_in      (mdr_in),
    .i_read        (read),
    .i_write       (write),
    .o_mdr_data    (mdr_data),
    .o_mem_addr    (mem_addr),
    .o_mem_wr_data (mem_wr_data),
    .o_mem_req     (mem_req),
    .o_mem_we      (mem_we),
    .i_mem_rd_data (rd_data),
    .i_mem_ack     (ack),
    .o_busy        (busy),
    .o_done        (done),
    .o_error       (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    mar_in  = 1'b0;
    mdr_in  = 1'b0;
    read    = 1'b0;
    write   = 1'b0;
    ack     = 1'b0;
    bus     = $urandom;
    rd_data = $urandom;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear();
    tick();
    reset = 1'b0;
    m_mar = '0;
    m_mdr = '0;
    m_err = 1'b0;
  endtask

  task automatic load_mar(input logic [DW-1:0] value);
    mar_in = 1'b1;
    bus    = value;
    tick();
    clear();
    m_mar = value[AW-1:0];
  endtask

  task automatic load_mdr(input logic [DW-1:0] value);
    mdr_in = 1'b1;
    bus    = value;
    tick();
    clear();
    m_mdr = value;
    chk("mdr_load", mdr_data, value);
    chk("mdr_load_busy", {31'd0, busy}, 32'd0);
  endtask

  // One transaction seen from outside: ack arrives in wait cycle 'lat'; lat > TMO means never.
  task automatic run_txn(input bit rd, input bit wr, input int lat,
                         input bit poke, input logic [AW-1:0] poke_addr, input bit extra);
    logic [AW-1:0] exp_addr = m_mar;
    logic [DW-1:0] exp_wd   = m_mdr;
    logic [DW-1:0] rdata    = tb_mem[m_mar];
    bit            acked    = (lat <= TMO);
    int            exp_req  = acked ? lat : TMO;
    int            req_cyc  = 0;
    int            done_cnt = 0;
    int            done_cyc = -1;
    int            idle_cyc = -1;
    bit            stable   = 1'b1;
    mdr_in = rd;
    read   = rd;
    write  = wr;
    tick();
    clear();
    for (int cyc = 1; cyc <= 40 && idle_cyc < 0; cyc++) begin
      if (mem_req) begin
        req_cyc++;
        if (mem_addr !== exp_addr || mem_we !== !rd || (!rd && mem_wr_data !== exp_wd)) stable = 1'b0;
        if (req_cyc == lat) begin
          ack     = 1'b1;
          rd_data = rdata;
        end
        if (req_cyc == 1 && poke) begin
          mar_in = 1'b1;
          bus    = {23'h0, poke_addr};
        end
        if (req_cyc == 1 && extra) begin
          read   = 1'b1;
          mdr_in = 1'b1;
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (!busy) idle_cyc = cyc;
      tick();
      clear();
    end
    if (poke) m_mar = poke_addr;
    if ((rd && wr) || extra || !acked) m_err = 1'b1;
    if (acked) begin
      if (rd) m_mdr = rdata;
      else tb_mem[exp_addr] = exp_wd;
    end
    chk("txn_req_cycles", req_cyc, exp_req);
    chk("txn_done_count", done_cnt, 1);
    chk("txn_done_cycle", done_cyc, exp_req + 1);
    chk("txn_idle_cycle", idle_cyc, exp_req + 2);
    chk("txn_req_stable", {31'd0, stable}, 32'd1);
    chk("txn_mdr", mdr_data, m_mdr);
    chk("txn_error", {31'd0, err}, {31'd0, m_err});
    chk("txn_req_low", {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    int kind;
    int lat;
    for (int a = 0; a < 512; a++) tb_mem[a] = $urandom;

    do_reset();
    tick();
    chk("rst_mdr", mdr_data, 0);
    chk("rst_addr", {23'd0, mem_addr}, 0);
    chk("rst_wdata", mem_wr_data, 0);
    chk("rst_req", {31'd0, mem_req}, 0);
    chk("rst_we", {31'd0, mem_we}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_error", {31'd0, err}, 0);

    load_mar(32'h0000_0123);
    load_mdr(32'hDEAD_BEEF);

    load_mar(32'h0000_0055);
    tb_mem[9'h055] = 32'h1234_5678;
    run_txn(1'b1, 1'b0, 3, 1'b0, '0, 1'b0);
    chk("rd_addr_055", {23'd0, mem_addr}, 32'h55);
    chk("rd_mdr_val", mdr_data, 32'h1234_5678);

    load_mar(32'h0000_01FF);
    load_mdr(32'hA5A5_A5A5);
    run_txn(1'b0, 1'b1, 1, 1'b1, 9'h000, 1'b0);
    chk("wr_addr_1ff", {23'd0, mem_addr}, 32'h1FF);
    chk("wr_data", mem_wr_data, 32'hA5A5_A5A5);
    chk("wr_we", {31'd0, mem_we}, 1);

    run_txn(1'b1, 1'b0, 99, 1'b0, '0, 1'b0);

    do_reset();
    chk("rst2_error", {31'd0, err}, 0);
    load_mar(32'h0000_0042);
    run_txn(1'b1, 1'b1, 2, 1'b0, '0, 1'b1);
    chk("rw_we_read", {31'd0, mem_we}, 0);

    do_reset();
    load_mar(32'h0000_0177);
    load_mdr(32'h0BAD_F00D);
    write = 1'b1;
    tick();
    clear();
    chk("midrst_req_before", {31'd0, mem_req}, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ack   = 1'b1;
    m_mar = '0;
    m_mdr = '0;
    m_err = 1'b0;
    chk("midrst_req", {31'd0, mem_req}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_done", {31'd0, done}, 0);
    chk("midrst_mdr", mdr_data, 0);
    chk("midrst_addr", {23'd0, mem_addr}, 0);
    chk("midrst_wdata", mem_wr_data, 0);
    chk("midrst_we", {31'd0, mem_we}, 0);
    tick();
    clear();
    chk("lateack_done", {31'd0, done}, 0);
    chk("lateack_busy", {31'd0, busy}, 0);
    chk("lateack_req", {31'd0, mem_req}, 0);
    chk("lateack_error", {31'd0, err}, 0);

    ack = 1'b1;
    tick();
    clear();
    chk("idle_ack_error", {31'd0, err}, 0);
    chk("idle_ack_mdr", mdr_data, m_mdr);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      lat  = ($urandom_range(0, 7) == 0) ? $urandom_range(16, 20) : $urandom_range(1, 6);
      case (kind)
        0: load_mar($urandom);
        1: load_mdr($urandom);
        2: run_txn(1'b1, 1'b0, lat, 1'b0, '0, 1'b0);
        default: run_txn(1'b0, 1'b1, lat, 1'b0, '0, 1'b0);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_interface.md
Name: memory_interface

Overview:
- Datapath/memory stage directly downstream of the control unit.
- Consumes the control unit's MARin, MDRin, Read and Write strobes and owns the MAR and MDR registers.
- Runs a request/acknowledge handshake to a variable-latency word memory.
- Returns MDR contents to the bus, and Busy/Done status that the control unit uses to stall its T-step sequencer.

Parameters:
- ADDR_WIDTH, 9, MAR width (512-word memory).
- DATA_WIDTH, 32, bus and memory word width.
- TIMEOUT_CYCLES, 15, maximum cycles to wait for MemAck before aborting (range 1..255).

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- BusMuxOut  in  DATA_WIDTH  internal bus value.
- MARin  in  1  load MAR from BusMuxOut[ADDR_WIDTH-1:0].
- MDRin  in  1  load MDR (source selected by Read).
- Read  in  1  with MDRin: fetch the word at MAR into MDR.
- Write  in  1  store MDR at the MAR address.
- MDRdata  out  DATA_WIDTH  current MDR contents, feeding the bus mux MDR input.
- MemAddr  out  ADDR_WIDTH  latched request address.
- MemWrData  out  DATA_WIDTH  latched store data.
- MemReq  out  1  request valid.
- MemWe  out  1  1 = write request, 0 = read request.
- MemRdData  in  DATA_WIDTH  read data, valid when MemAck=1.
- MemAck  in  1  memory completion, one cycle.
- Busy  out  1  transaction outstanding.
- Done  out  1  one-cycle completion pulse.
- Error  out  1  sticky fault flag.

Behaviour:
- Reset (synchronous): MAR=0, MDR=0, MemAddr=0, MemWrData=0, MemReq=0, MemWe=0, Busy=0, Done=0, Error=0, state=IDLE, timeout counter=0.
- Reset mid-transaction aborts the transaction. MemReq is low in the cycle after the Reset edge. A late MemAck is ignored.
- MARin (any state): MAR <= BusMuxOut[ADDR_WIDTH-1:0]. Does not affect an in-flight MemAddr.
- MDRin & !Read in IDLE: MDR <= BusMuxOut in the same edge.
- FSM states: IDLE, RD_WAIT, WR_WAIT, COMPLETE.
- IDLE → RD_WAIT on MDRin & Read:
  - MemAddr <= MAR, MemWe <= 0, MemReq <= 1, Busy <= 1.
  - Counter cleared.
- IDLE → WR_WAIT on Write (MDRin ignored for this cycle):
  - MemAddr <= MAR, MemWrData <= MDR, MemWe <= 1, MemReq <= 1, Busy <= 1.
- Read & Write together in IDLE: read is performed and Error <= 1.
- RD_WAIT on MemAck: MDR <= MemRdData, MemReq <= 0, go to COMPLETE.
- WR_WAIT on MemAck: MemReq <= 0, go to COMPLETE.
- RD_WAIT/WR_WAIT without MemAck: counter increments. Reaching TIMEOUT_CYCLES gives MemReq <= 0, Error <= 1, go to COMPLETE, MDR unchanged.
- COMPLETE: Done=1 and Busy=1 for exactly one cycle, then IDLE with Busy=0.
- Minimum latency is 3 edges from the request edge to the Done pulse end, with MemAck asserted in the first wait cycle.
- Read, Write or MDRin arriving while not in IDLE: ignored, Error <= 1, MDR unchanged.
- MemAck while MemReq=0: ignored, no error.
- MemReq, MemWe, MemAddr and MemWrData are stable from request until ack or timeout.
- Error clears only on Reset.

Decomposition:
- Shared package (minisrc_pkg), shared with the control unit:
  - state encoding enum for IDLE/RD_WAIT/WR_WAIT/COMPLETE;
  - ADDR_WIDTH/DATA_WIDTH defaults;
  - TIMEOUT_CYCLES default.
- One natural sub-module: mem_handshake_fsm.
  - Contains the state register, timeout counter, and MemReq/MemWe/Busy/Done/Error generation.
  - The MAR/MDR registers and data muxing stay in the top.

Test Plan:
- Reset, then BusMuxOut=0x0000_0123 with MARin=1 → MAR=0x123. Next MDRin=1, Read=0, BusMuxOut=0xDEAD_BEEF → MDRdata=0xDEAD_BEEF, Busy stays 0.
- MAR=0x055, pulse MDRin+Read; memory acks 3 cycles later with 0x1234_5678 → MemAddr=0x055, MemWe=0, MemReq held 3 cycles, MDRdata=0x1234_5678, one Done pulse, Busy falls after Done.
- MAR=0x1FF, MDR=0xA5A5_A5A5, pulse Write; change MAR to 0x000 mid-wait; ack after 1 cycle → MemAddr stays 0x1FF, MemWrData=0xA5A5_A5A5, MemWe=1, Done pulse.
- Read request, MemAck never asserted (TIMEOUT_CYCLES=15) → MemReq drops after 15 wait cycles, Error=1, Done pulses, MDR unchanged.
- Read and Write asserted together → read performed, Error=1. A second Read during RD_WAIT → ignored, single transaction completes.
- Reset asserted during WR_WAIT, then MemAck next cycle → MemReq=0 and all outputs 0 after the Reset edge, no Done pulse, state IDLE.
